shader_prog_loader: RTL and testbench
=====================================

Name: shader_prog_loader

Overview:
- SPI-slave controller that configures the tiny shader's instruction memory.
- Receives shader programs over the bidir PMOD SPI pins into a shadow register bank.
- Commits the shadow bank to the active bank only on a frame boundary (next_frame), so a program never changes mid-frame.
- Serves the active bank to the shader core through an asynchronous read port.

Parameters:
NUM_INSTR, 16, number of instruction slots (power of two, ≥2)
INSTR_W, 8, instruction width in bits (fixed at 8: one SPI byte per instruction)

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active-high
spi_sclk_i  in  1  SPI clock, mode 0, asynchronous to clk_i, f_sclk ≤ f_clk/4
spi_cs_ni  in  1  SPI chip select, active-low, asynchronous
spi_mosi_i  in  1  SPI data in, asynchronous
spi_miso_o  out  1  SPI data out
next_frame_i  in  1  one-cycle pulse from timing generator at frame start
instr_addr_i  in  $clog2(NUM_INSTR)  shader read address
instr_o  out  INSTR_W  active[instr_addr_i], combinational
commit_pending_o  out  1  commit requested, not yet applied
busy_o  out  1  SPI transaction in progress (synced CS low)

Behaviour:
- Reset: all state synchronous to clk_i and active-high.
  - On rst_i, all outputs are 0: spi_miso_o=0, commit_pending_o=0, busy_o=0.
  - Active and shadow banks clear to 0x00, so instr_o=0.
  - FSM goes to IDLE; bit and address counters go to 0.
- Input sync: sclk, cs_n and mosi each pass through a 2-flop synchronizer.
  - sclk rise is detected on the synced signal vs its delayed copy; sclk fall likewise.
  - Edge event latency is 3 clk_i cycles from the pin.
- SPI framing: data is MSB first.
  - MOSI is sampled on the sclk rise event.
  - MISO is updated on the sclk fall event.
- FSM states: IDLE, CMD, WRITE, READ, IGNORE.
  - IDLE -> CMD when synced cs_n falls; bit counter=0, address=0.
  - CMD: shift 8 bits, then decode the byte:
    - 0x00 -> WRITE.
    - 0x01 -> set the commit request, then IGNORE.
    - 0x02 -> READ; load active[0] into the TX shift register.
    - Any other value -> IGNORE.
  - WRITE: each completed byte is written to shadow[address], then address increments.
    - The address wraps from NUM_INSTR-1 to 0.
  - READ: on each sclk fall, spi_miso_o takes the TX register MSB and the register shifts left.
    - After the 8th bit has been presented, the next fall presents bit 7 of active[address+1].
    - The address wraps.
  - IGNORE: all SCLK edges are ignored.
- Any state -> IDLE the cycle synced cs_n is high.
  - A partial byte is discarded.
  - spi_miso_o is driven 0 while idle.
- Commit handshake:
  - commit_pending_o is set the cycle after the COMMIT byte completes.
  - On a next_frame_i pulse while pending=1: all NUM_INSTR shadow entries are copied into active in one cycle, and pending clears the same cycle.
  - COMMIT completing in the same cycle as next_frame_i: pending sets and the copy waits for the following next_frame_i.
  - A shadow write in the same cycle as the copy: the copy uses pre-write shadow contents. The write lands only in shadow.
  - A repeated COMMIT while pending has no additional effect.
  - next_frame_i with pending=0 does nothing.
- busy_o = synced cs_n inverted, i.e. FSM not in IDLE.
- Active bank is never written except by the commit copy.
  - READ always returns active, never shadow.

Test Plan:
- Reset:
  - Stimulus: assert rst_i 2 cycles with garbage on SPI pins.
  - Required: all outputs 0, instr_o=0x00 for every address, FSM IDLE.
- Write then commit:
  - Stimulus: CS low, send 0x00, then 0x10..0x1F, CS high. Then send 0x01 and pulse next_frame_i.
  - Required: instr_o stays 0x00 until the next_frame_i pulse.
  - Required: commit_pending_o=1 before the pulse and 0 after it.
  - Required: afterwards instr_o[a]=0x10+a.
- Wrap:
  - Stimulus: send 0x00 followed by 18 bytes 0xA0..0xB1, then commit.
  - Required: active[0]=0xB0, active[1]=0xB1, active[2]=0xA2.
- Readback:
  - Stimulus: after the write-then-commit scenario, send 0x02 and clock out 3 bytes.
  - Required: MISO bytes 0x10, 0x11, 0x12.
- Aborted byte and unknown command:
  - Stimulus: send 0x00 and 5 bits, then raise CS.
  - Required: shadow unchanged, state returns to IDLE.
  - Stimulus: send 0x7E followed by 0x55.
  - Required: no write, no pending.
- Simultaneous events:
  - Stimulus: COMMIT byte completes in the same cycle as next_frame_i.
  - Required: pending=1 and no copy; the copy happens on the next pulse.
  - Stimulus: rst_i asserted mid-WRITE.
  - Required: banks are 0 and pending=0.

Source files
------------

// File: rtl/shader_prog_loader.sv
// rtl/shader_prog_loader.sv - SPI-slave loader for the shader instruction memory with frame-aligned commit
module shader_prog_loader #(
  parameter int NUM_INSTR = 16,
  parameter int INSTR_W   = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         spi_sclk_i,
  input  logic                         spi_cs_ni,
  input  logic                         spi_mosi_i,
  output logic                         spi_miso_o,
  input  logic                         next_frame_i,
  input  logic [$clog2(NUM_INSTR)-1:0] instr_addr_i,
  output logic [INSTR_W-1:0]           instr_o,
  output logic                         commit_pending_o,
  output logic                         busy_o
);

  localparam int AW = $clog2(NUM_INSTR);

  localparam logic [INSTR_W-1:0] CMD_WRITE  = 8'h00;
  localparam logic [INSTR_W-1:0] CMD_COMMIT = 8'h01;
  localparam logic [INSTR_W-1:0] CMD_READ   = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WRITE,
    ST_READ,
    ST_IGNORE
  } state_t;

  state_t state_q, state_d;

  logic [1:0] sclk_sync;
  logic [1:0] cs_sync;
  logic [1:0] mosi_sync;
  logic       sclk_dly;

  logic [INSTR_W-1:0] shadow_q [NUM_INSTR];
  logic [INSTR_W-1:0] active_q [NUM_INSTR];

  logic [INSTR_W-2:0] rx_sh_q;
  logic [INSTR_W-1:0] tx_sh_q;
  logic [2:0]         bit_cnt_q;
  logic [2:0]         tx_cnt_q;
  logic [AW-1:0]      addr_q;
  logic               miso_q;
  logic               pending_q;

  logic               sclk_rise;
  logic               sclk_fall;
  logic               cs_high;
  logic               byte_done;
  logic [INSTR_W-1:0] rx_byte;
  logic               commit_hit;
  logic               do_copy;
  logic [AW-1:0]      addr_next;

  assign sclk_rise  = sclk_sync[1] & ~sclk_dly;
  assign sclk_fall  = ~sclk_sync[1] & sclk_dly;
  assign cs_high    = cs_sync[1];
  assign rx_byte    = {rx_sh_q, mosi_sync[1]};
  assign byte_done  = sclk_rise && (bit_cnt_q == 3'd7);
  assign commit_hit = !cs_high && (state_q == ST_CMD) && byte_done && (rx_byte == CMD_COMMIT);
  assign do_copy    = next_frame_i && pending_q;
  assign addr_next  = addr_q + AW'(1);

  assign instr_o          = active_q[instr_addr_i];
  assign commit_pending_o = pending_q;
  assign busy_o           = (state_q != ST_IDLE);
  assign spi_miso_o       = miso_q;

  // Two-flop synchronizers for the SPI pins plus the delayed sclk copy used for edge detection.
  // CS resets to the inactive level so a floating pin cannot start a transaction out of reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_sync <= 2'b00;
      cs_sync   <= 2'b11;
      mosi_sync <= 2'b00;
      sclk_dly  <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], spi_sclk_i};
      cs_sync   <= {cs_sync[0], spi_cs_ni};
      mosi_sync <= {mosi_sync[0], spi_mosi_i};
      sclk_dly  <= sclk_sync[1];
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: CS high forces IDLE from anywhere; the command byte selects the mode.
  always_comb begin
    state_d = state_q;
    if (cs_high) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_CMD;
        ST_CMD: begin
          if (byte_done) begin
            case (rx_byte)
              CMD_WRITE: state_d = ST_WRITE;
              CMD_READ:  state_d = ST_READ;
              default:   state_d = ST_IGNORE;
            endcase
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Shift registers, counters, shadow writes and MISO drive; everything idles cleared while CS is high.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_sh_q   <= '0;
      tx_sh_q   <= '0;
      bit_cnt_q <= '0;
      tx_cnt_q  <= '0;
      addr_q    <= '0;
      miso_q    <= 1'b0;
      for (int i = 0; i < NUM_INSTR; i++) shadow_q[i] <= '0;
    end else if (cs_high || state_q == ST_IDLE) begin
      rx_sh_q   <= '0;
      bit_cnt_q <= '0;
      tx_cnt_q  <= '0;
      addr_q    <= '0;
      miso_q    <= 1'b0;
    end else begin
      if (sclk_rise && (state_q == ST_CMD || state_q == ST_WRITE)) begin
        rx_sh_q   <= rx_byte[INSTR_W-2:0];
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end
      if (state_q == ST_CMD && byte_done && rx_byte == CMD_READ) begin
        tx_sh_q  <= active_q[0];
        tx_cnt_q <= '0;
      end
      if (state_q == ST_WRITE && byte_done) begin
        shadow_q[addr_q] <= rx_byte;
        addr_q           <= addr_next;
      end
      if (state_q == ST_READ && sclk_fall) begin
        miso_q <= tx_sh_q[INSTR_W-1];
        if (tx_cnt_q == 3'd7) begin
          tx_sh_q  <= active_q[addr_next];
          addr_q   <= addr_next;
          tx_cnt_q <= '0;
        end else begin
          tx_sh_q  <= {tx_sh_q[INSTR_W-2:0], 1'b0};
          tx_cnt_q <= tx_cnt_q + 3'd1;
        end
      end
    end
  end

  // Commit handshake: a pending request copies the whole shadow bank on the next frame pulse.
  // A COMMIT landing on the same pulse only arms the request, so the copy waits one frame.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= 1'b0;
      for (int i = 0; i < NUM_INSTR; i++) active_q[i] <= '0;
    end else if (do_copy) begin
      pending_q <= 1'b0;
      for (int i = 0; i < NUM_INSTR; i++) active_q[i] <= shadow_q[i];
    end else if (commit_hit) begin
      pending_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_shader_prog_loader.sv
// tb/tb_shader_prog_loader.sv - randomized self-checking bench for shader_prog_loader
module tb_shader_prog_loader;

  localparam int N = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic       next_frame = 1'b0;
  logic [3:0] instr_addr = '0;
  logic [7:0] instr;
  logic       pending;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_shadow [N];
  logic [7:0] m_active [N];
  bit         m_pending;
  logic [7:0] wq [$];

  shader_prog_loader #(.NUM_INSTR(N), .INSTR_W(8)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .spi_sclk_i       (sclk),
    .spi_cs_ni        (cs_n),
    .spi_mosi_i       (mosi),
    .spi_miso_o       (miso),
    .next_frame_i     (next_frame),
    .instr_addr_i     (instr_addr),
    .instr_o          (instr),
    .commit_pending_o (pending),
    .busy_o           (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_shadow[i] = 8'h00;
      m_active[i] = 8'h00;
    end
    m_pending = 1'b0;
  endtask

  task automatic model_frame();
    if (m_pending) begin
      for (int i = 0; i < N; i++) m_active[i] = m_shadow[i];
      m_pending = 1'b0;
    end
  endtask

  // One SPI mode-0 byte, sclk toggled on clk negedges with a 4-cycle half period.
  // nf_on_done pulses next_frame in the exact cycle the last rise is acted on.
  task automatic spi_bits(input logic [7:0] tx, input int nbits, input bit nf_on_done,
                          output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      mosi = tx[i];
      repeat (4) @(negedge clk);
      rx[i] = miso;
      sclk = 1'b1;
      if (nf_on_done && i == 0) begin
        repeat (2) @(negedge clk);
        next_frame = 1'b1;
        @(negedge clk);
        next_frame = 1'b0;
        @(negedge clk);
      end else begin
        repeat (4) @(negedge clk);
      end
      sclk = 1'b0;
    end
  endtask

  task automatic cs_begin();
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (5) @(negedge clk);
    cs_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic send_write();
    logic [7:0] rx;
    cs_begin();
    spi_bits(8'h00, 8, 1'b0, rx);
    for (int k = 0; k < wq.size(); k++) begin
      spi_bits(wq[k], 8, 1'b0, rx);
      m_shadow[k % N] = wq[k];
    end
    cs_end();
  endtask

  task automatic send_commit(input bit nf_on_done);
    logic [7:0] rx;
    cs_begin();
    spi_bits(8'h01, 8, nf_on_done, rx);
    cs_end();
    if (nf_on_done && m_pending) model_frame();
    else m_pending = 1'b1;
  endtask

  task automatic pulse_frame();
    @(negedge clk);
    next_frame = 1'b1;
    @(negedge clk);
    next_frame = 1'b0;
    model_frame();
    @(negedge clk);
  endtask

  task automatic check_active(input string tag);
    for (int a = 0; a < N; a++) begin
      @(negedge clk);
      instr_addr = 4'(a);
      #1;
      check($sformatf("%s[%0d]", tag, a), {24'h0, instr}, {24'h0, m_active[a]});
    end
  endtask

  task automatic readback(input string tag, input int nbytes);
    logic [7:0] rx;
    cs_begin();
    spi_bits(8'h02, 8, 1'b0, rx);
    for (int k = 0; k < nbytes; k++) begin
      spi_bits(8'h00, 8, 1'b0, rx);
      check($sformatf("%s_rd%0d", tag, k), {24'h0, rx}, {24'h0, m_active[k % N]});
    end
    cs_end();
  endtask

  initial begin
    logic [7:0] rx;
    model_reset();

    // Reset with garbage on the SPI pins.
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      sclk = 1'($urandom);
      cs_n = 1'($urandom);
      mosi = 1'($urandom);
    end
    @(negedge clk);
    check("rst_miso", {31'h0, miso}, 32'h0);
    check("rst_pending", {31'h0, pending}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    sclk = 1'b0;
    cs_n = 1'b1;
    mosi = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_active("rst_instr");
    check("idle_busy", {31'h0, busy}, 32'h0);

    // Write 0x10..0x1F, then commit on a frame boundary.
    wq.delete();
    for (int k = 0; k < 16; k++) wq.push_back(8'h10 + 8'(k));
    cs_begin();
    check("busy_in_xfer", {31'h0, busy}, 32'h1);
    cs_end();
    send_write();
    check_active("pre_commit");
    send_commit(1'b0);
    check("pending_set", {31'h0, pending}, {31'h0, m_pending});
    check_active("pending_hold");
    pulse_frame();
    check("pending_clr", {31'h0, pending}, 32'h0);
    check_active("post_commit");
    instr_addr = 4'd5;
    #1;
    check("commit_a5_const", {24'h0, instr}, 32'h15);

    // Readback of the active bank.
    readback("rb", 3);
    check("idle_miso", {31'h0, miso}, 32'h0);

    // Address wrap with 18 bytes.
    wq.delete();
    for (int k = 0; k < 18; k++) wq.push_back(8'hA0 + 8'(k));
    send_write();
    send_commit(1'b0);
    pulse_frame();
    check_active("wrap");
    @(negedge clk);
    instr_addr = 4'd0;
    #1;
    check("wrap_a0_const", {24'h0, instr}, 32'hB0);
    instr_addr = 4'd2;
    #1;
    check("wrap_a2_const", {24'h0, instr}, 32'hA2);

    // Aborted partial byte leaves shadow untouched.
    cs_begin();
    spi_bits(8'h00, 8, 1'b0, rx);
    spi_bits(8'hFF, 5, 1'b0, rx);
    cs_end();
    check("abort_busy", {31'h0, busy}, 32'h0);

    // Unknown command followed by data: no write, no pending.
    cs_begin();
    spi_bits(8'h7E, 8, 1'b0, rx);
    spi_bits(8'h55, 8, 1'b0, rx);
    cs_end();
    check("unk_pending", {31'h0, pending}, 32'h0);
    pulse_frame();
    check_active("unk_nf_noop");
    send_commit(1'b0);
    pulse_frame();
    check_active("abort_unk_shadow");

    // Randomized write/commit/readback rounds.
    for (int it = 0; it < 6; it++) begin
      int len;
      len = $urandom_range(1, 20);
      wq.delete();
      for (int k = 0; k < len; k++) wq.push_back(8'($urandom));
      send_write();
      if ($urandom_range(0, 1) == 1) begin
        send_commit(1'b0);
        if ($urandom_range(0, 1) == 1) send_commit(1'b0);
        check($sformatf("rnd%0d_pending", it), {31'h0, pending}, {31'h0, m_pending});
        pulse_frame();
      end
      check($sformatf("rnd%0d_pending_after", it), {31'h0, pending}, {31'h0, m_pending});
      readback($sformatf("rnd%0d", it), $urandom_range(1, 5));
    end
    check_active("rnd_final");

    // COMMIT completing on the same cycle as next_frame: arm only, copy on next pulse.
    if (m_pending) pulse_frame();
    wq.delete();
    for (int k = 0; k < N; k++) wq.push_back(8'hC0 ^ 8'(k * 7));
    send_write();
    send_commit(1'b1);
    check("simul_pending", {31'h0, pending}, 32'h1);
    check_active("simul_nocopy");
    pulse_frame();
    check("simul_pending_clr", {31'h0, pending}, 32'h0);
    check_active("simul_copy");

    // Reset in the middle of a WRITE transaction.
    send_commit(1'b0);
    cs_begin();
    spi_bits(8'h00, 8, 1'b0, rx);
    spi_bits(8'h99, 8, 1'b0, rx);
    spi_bits(8'h98, 8, 1'b0, rx);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cs_n = 1'b1;
    model_reset();
    repeat (5) @(negedge clk);
    check("midrst_pending", {31'h0, pending}, 32'h0);
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check_active("midrst_active");
    send_commit(1'b0);
    pulse_frame();
    check_active("midrst_shadow");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
